// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the control unit.
// Holds the default program-counter and instruction widths, the position
// of the opcode field and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;
  // Opcode occupies the top OPCODE_W bits of an instruction word.
  localparam int OPCODE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (PC -> 0)
//   inc_en       : advance PC by one, wrapping modulo 2^PC_W
//   load_en      : load load_value (wins over inc_en)
//   load_value   : redirect address
//   pc           : current program counter
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_en,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_value,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load_en) begin
      pc <= load_value;
    end else if (inc_en) begin
      // Natural overflow of the PC_W-bit add gives the wrap to zero.
      pc <= pc + PC_ONE;
    end
  end

endmodule : program_counter

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests words from instruction memory, holds
// one fetched instruction in an output slot until downstream consumes it,
// and redirects the PC on jump or taken branch at consume time.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/imem_addr  : read request and word address (always the PC)
//   imem_ack/imem_rdata : acknowledge with same-cycle read data
//   stall               : downstream not consuming the slot
//   jump, branch,       : redirect controls for the slotted instruction,
//   alu_zero, target      only acted on during a consume
//   instr, instr_valid  : output slot
//   control_opcode      : opcode field of instr
//   pc_out              : address instr was fetched from
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [OPCODE_W-1:0] control_opcode,
  output logic [PC_W-1:0]    pc_out
);

  fetch_state_t    state_reg, state_next;
  logic            fetch_en;
  logic            consume;
  logic            redirect;
  logic [PC_W-1:0] pc;

  // The slot is only ever full in WAIT, so this is the consume condition.
  assign consume  = instr_valid & ~stall;
  // Jump and taken branch share one effect; both asserted is still one load.
  assign redirect = consume & (jump | (branch & alu_zero));

  program_counter #(
    .PC_W(PC_W)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (fetch_en),
    .load_en   (redirect),
    .load_value(target),
    .pc        (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    fetch_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        // Stall is deliberately not looked at: an outstanding request
        // completes regardless of downstream back-pressure.
        if (imem_ack) begin
          fetch_en   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (consume) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output slot: loaded on an acknowledged request, emptied on consume,
  // otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr          <= '0;
      instr_valid    <= 1'b0;
      control_opcode <= '0;
      pc_out         <= '0;
    end else if (fetch_en) begin
      instr          <= imem_rdata;
      instr_valid    <= 1'b1;
      control_opcode <= imem_rdata[INSTR_W-1 -: OPCODE_W];
      pc_out         <= pc;
    end else if (consume) begin
      instr_valid    <= 1'b0;
    end
  end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch against a
// transaction-level reference model of the fetch slot.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        alu_zero;
  logic [7:0]  target;
  logic [15:0] instr;
  logic        instr_valid;
  logic [2:0]  control_opcode;
  logic [7:0]  pc_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];

  // Reference model: the PC, the slot contents, and whether we are in the
  // single quiet cycle that follows reset.
  logic        m_boot;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [7:0]  m_pcout;

  always #5 clk = ~clk;

  instruction_fetch #(
    .PC_W   (8),
    .INSTR_W(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .jump          (jump),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .target        (target),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .control_opcode(control_opcode),
    .pc_out        (pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the rising edge.
  task automatic tick(input logic rst, input logic ack, input logic stl,
                      input logic jmp, input logic br, input logic zr,
                      input logic [7:0] tgt);
    logic [15:0] rd;
    reset    = rst;
    imem_ack = ack;
    stall    = stl;
    jump     = jmp;
    branch   = br;
    alu_zero = zr;
    target   = tgt;
    rd = ack ? mem[imem_addr] : 16'($urandom);
    imem_rdata = rd;
    #1;
    // A request is outstanding exactly when the slot is empty, except in
    // the quiet cycle after reset.
    chk("req",    32'(imem_req),       32'(!m_boot && !m_valid));
    chk("addr",   32'(imem_addr),      32'(m_pc));
    chk("instr",  32'(instr),          32'(m_instr));
    chk("valid",  32'(instr_valid),    32'(m_valid));
    chk("opcode", 32'(control_opcode), 32'(m_instr[15:13]));
    chk("pc_out", 32'(pc_out),         32'(m_pcout));
    @(posedge clk);
    if (rst) begin
      m_boot = 1'b1; m_pc = 8'h00; m_valid = 1'b0; m_instr = 16'h0; m_pcout = 8'h00;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_valid) begin
      if (ack) begin
        m_instr = rd;
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 8'd1;
        $display("fetch addr=%02h instr=%04h", m_pcout, m_instr);
      end
    end else if (!stl) begin
      m_valid = 1'b0;
      if (jmp || (br && zr)) m_pc = tgt;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h6000;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
    jump = 1'b0; branch = 1'b0; alu_zero = 1'b0; target = 8'h00;
    m_boot = 1'b1; m_pc = 8'h00; m_valid = 1'b0; m_instr = 16'h0; m_pcout = 8'h00;
    @(posedge clk);
    @(negedge clk);

    // Reset state, then zero-wait fetch of 16'h6000 from address 0.
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 0, 0, 8'h00);
    chk("boot_valid",  32'(instr_valid),    32'h1);
    chk("boot_instr",  32'(instr),          32'h6000);
    chk("boot_opcode", 32'(control_opcode), 32'h3);
    chk("boot_pc_out", 32'(pc_out),         32'h0);

    // Stall for four cycles with a full slot, then release.
    repeat (4) tick(0, 1, 1, 1, 0, 0, 8'h77);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    chk("stall_release_addr", 32'(imem_addr), 32'h1);
    chk("stall_release_req",  32'(imem_req),  32'h1);

    // Ack delayed three cycles.
    repeat (3) tick(0, 0, 0, 0, 0, 0, 8'h00);
    chk("delay_valid_low", 32'(instr_valid), 32'h0);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    chk("delay_valid_high", 32'(instr_valid), 32'h1);

    // Jump, branch not taken, branch taken, then the PC wrap.
    tick(0, 0, 0, 1, 0, 0, 8'h40);
    chk("jump_addr", 32'(imem_addr), 32'h40);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 1, 0, 8'h99);
    chk("branch_nt_addr", 32'(imem_addr), 32'h41);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 1, 1, 8'h10);
    chk("branch_t_addr", 32'(imem_addr), 32'h10);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 1, 1, 1, 8'hFF);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    chk("wrap_pc_out", 32'(pc_out),    32'hFF);
    chk("wrap_addr",   32'(imem_addr), 32'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);

    // Reset while a request is outstanding; the late ack must be ignored.
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_mid_req", 32'(imem_req), 32'h0);
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    chk("refetch_req",  32'(imem_req),  32'h1);
    chk("refetch_addr", 32'(imem_addr), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_W, default 8, SHALL set program-counter / instruction-memory word-address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set instruction width; opcode field SHALL be instr[INSTR_W-1:INSTR_W-3].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be the read request to instruction memory.
REQ-006 imem_addr  output  PC_W  SHALL be the word address of the request, equal to current PC.
REQ-007 imem_ack  input  1  SHALL be the memory acknowledge; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  INSTR_W  SHALL be the returned instruction word.
REQ-009 stall  input  1  SHALL hold the output slot when 1 (downstream not consuming).
REQ-010 jump  input  1  SHALL be the control-unit jump for the slotted instruction.
REQ-011 branch  input  1  SHALL be the control-unit branch for the slotted instruction.
REQ-012 alu_zero  input  1  SHALL be the branch condition; branch taken = branch & alu_zero.
REQ-013 target  input  PC_W  SHALL be the redirect address for jump or taken branch.
REQ-014 instr  output  INSTR_W  SHALL be the registered fetched instruction.
REQ-015 instr_valid  output  1  SHALL flag that instr holds an unconsumed instruction.
REQ-016 control_opcode  output  3  SHALL be the registered opcode field of instr, feeding the control unit.
REQ-017 pc_out  output  PC_W  SHALL be the address from which instr was fetched.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT.
REQ-019 IDLE SHALL drive imem_req=0 and go to REQ unconditionally next cycle.
REQ-020 REQ SHALL drive imem_req=1, imem_addr=PC; on imem_ack it SHALL load instr=imem_rdata, control_opcode=opcode field, pc_out=PC, instr_valid=1, PC=PC+1, next state WAIT; without imem_ack it SHALL stay in REQ with address stable.
REQ-021 Zero-wait memory (ack in first REQ cycle) SHALL give instr_valid=1 two cycles after reset deasserts.
REQ-022 PC increment SHALL wrap modulo 2^PC_W (all-ones + 1 = 0).
REQ-023 Consume SHALL be defined as a cycle with instr_valid=1 and stall=0.
REQ-024 WAIT SHALL drive imem_req=0; on consume it SHALL clear instr_valid and go to REQ; otherwise hold instr, control_opcode, pc_out, instr_valid unchanged.
REQ-025 On consume with jump=1 or (branch=1 and alu_zero=1), PC SHALL load target instead of its incremented value; next request address = target.
REQ-026 jump/branch/alu_zero/target SHALL be ignored unless consume is true; jump takes same effect as taken branch if both are asserted.
REQ-027 imem_ack outside REQ SHALL be ignored; stall SHALL NOT affect an outstanding REQ.
REQ-028 At most one request SHALL be outstanding; no new request while instr_valid=1 and not consumed.

Reset
REQ-029 Reset SHALL force state=IDLE, PC=0, imem_req=0, imem_addr=0, instr=0, instr_valid=0, control_opcode=0, pc_out=0.
REQ-030 Reset asserted mid-REQ SHALL drop imem_req at that edge; a late ack SHALL have no effect.
REQ-031 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-032 PC_W, INSTR_W, opcode bit positions and FSM state encodings SHALL live in a shared include header used by the fetch and control-unit designs.
REQ-033 A program_counter sub-module (register with reset, increment-with-wrap, load-target) SHALL be instantiated; FSM and output slot stay in instruction_fetch.

Verification
REQ-034 Reset, zero-wait memory returning 16'h6000 at addr 0 -> imem_addr=0, instr_valid=1 two cycles after reset, control_opcode=3'b011, pc_out=0.
REQ-035 Ack delayed 3 cycles -> imem_req held 1, imem_addr constant 3 cycles; instr_valid rises the cycle after ack.
REQ-036 stall=1 for 4 cycles with instr_valid=1 -> instr/control_opcode stable, imem_req=0, no PC change; release -> next request at PC+1.
REQ-037 Consume with jump=1, target=8'h40 -> next imem_addr=8'h40; branch=1, alu_zero=0 -> next imem_addr=pc_out+1; branch=1, alu_zero=1, target=8'h10 -> 8'h10.
REQ-038 PC=8'hFF fetched -> next imem_addr=8'h00.
REQ-039 Reset asserted while imem_req=1, ack in following cycle -> instr_valid stays 0, refetch from addr 0.
